// File: rtl/dot_product_accum_pkg.sv
// Shared constants and state encoding for the dot-product accumulation stage.
package dot_pkg;
   localparam int ELEM_W       = 8;
   localparam int NUM_ELEMENTS = 8;
   localparam int DOT_W        = 19;
   localparam int ACC_W_DEF    = 32;

   typedef enum logic [1:0] {
      IDLE,
      ACCUM,
      DONE
   } accum_state_t;
endpackage

// File: rtl/dot_product_accum_sat_add.sv
// Saturating unsigned add of a narrow partial product onto a wide running sum.
module dot_sat_add
   import dot_pkg::*;
#(
   parameter int IN_W  = DOT_W,
   parameter int ACC_W = ACC_W_DEF
) (
   input  logic [IN_W-1:0]  a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             sat
);

   logic [ACC_W:0] wide;

   always_comb begin
      wide = {1'b0, b} + {{(ACC_W - IN_W + 1){1'b0}}, a};
      sat  = wide[ACC_W];
      sum  = sat ? '1 : wide[ACC_W-1:0];
   end

endmodule

// File: rtl/dot_product_accum.sv
// Frame accumulator: sums partial dot products per frame and presents the
// result, beat count and status flags over a valid/ready handshake.
module dot_product_accum
   import dot_pkg::*;
#(
   parameter int IN_W      = DOT_W,
   parameter int ACC_W     = ACC_W_DEF,
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_dot,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_sum,
   output logic [CNT_W-1:0] out_beats,
   output logic             out_ovf,
   output logic             out_trunc
);

   accum_state_t     state_q, state_d;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic             trunc_q, trunc_d;

   logic [ACC_W-1:0] base, add_sum;
   logic [CNT_W-1:0] cnt_inc;
   logic             sat, accept, at_max, close;

   dot_sat_add #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
   ) u_sat_add (
      .a   (in_dot),
      .b   (base),
      .sum (add_sum),
      .sat (sat)
   );

   // The running sum and flags double as the output registers: they freeze in
   // DONE and are cleared on the handshake, so no separate result copy exists.
   always_comb begin
      base    = (state_q == ACCUM) ? acc_q : '0;
      cnt_inc = (state_q == ACCUM) ? cnt_q + CNT_W'(1) : CNT_W'(1);
      at_max  = (cnt_inc == CNT_W'(MAX_BEATS));
      accept  = in_valid && (state_q != DONE);
      close   = accept && (in_last || at_max);

      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      trunc_d = trunc_q;

      unique case (state_q)
         IDLE, ACCUM: begin
            if (accept) begin
               acc_d   = add_sum;
               cnt_d   = cnt_inc;
               ovf_d   = ((state_q == ACCUM) && ovf_q) || sat;
               trunc_d = close && at_max && !in_last;
               state_d = close ? DONE : ACCUM;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
               ovf_d   = 1'b0;
               trunc_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         trunc_q <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         trunc_q <= trunc_d;
      end
   end

   assign in_ready  = (state_q != DONE);
   assign out_valid = (state_q == DONE);
   assign out_sum   = acc_q;
   assign out_beats = cnt_q;
   assign out_ovf   = ovf_q;
   assign out_trunc = trunc_q;

endmodule

// File: tb/tb_dot_product_accum.sv
// Directed bench: vector table on the default build, plus hand sequences for
// saturation (ACC_W=20), forced close (MAX_BEATS=4) and asynchronous reset.
module tb_dot_product_accum;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_pass  = 0;

   // default instance
   logic        v_a = 1'b0, l_a = 1'b0, or_a = 1'b0;
   logic [18:0] d_a = '0;
   logic        ir_a, ov_a, ovf_a, tr_a;
   logic [31:0] s_a;
   logic [8:0]  b_a;

   // ACC_W=20 instance
   logic        v_b = 1'b0, l_b = 1'b0, or_b = 1'b0;
   logic [18:0] d_b = '0;
   logic        ir_b, ov_b, ovf_b, tr_b;
   logic [19:0] s_b;
   logic [8:0]  b_b;

   // MAX_BEATS=4 instance
   logic        v_c = 1'b0, l_c = 1'b0, or_c = 1'b0;
   logic [18:0] d_c = '0;
   logic        ir_c, ov_c, ovf_c, tr_c;
   logic [31:0] s_c;
   logic [2:0]  b_c;

   dot_product_accum u_dut_a (
      .clk(clk), .rst(rst), .in_valid(v_a), .in_ready(ir_a), .in_dot(d_a),
      .in_last(l_a), .out_valid(ov_a), .out_ready(or_a), .out_sum(s_a),
      .out_beats(b_a), .out_ovf(ovf_a), .out_trunc(tr_a)
   );

   dot_product_accum #(.ACC_W(20)) u_dut_b (
      .clk(clk), .rst(rst), .in_valid(v_b), .in_ready(ir_b), .in_dot(d_b),
      .in_last(l_b), .out_valid(ov_b), .out_ready(or_b), .out_sum(s_b),
      .out_beats(b_b), .out_ovf(ovf_b), .out_trunc(tr_b)
   );

   dot_product_accum #(.MAX_BEATS(4)) u_dut_c (
      .clk(clk), .rst(rst), .in_valid(v_c), .in_ready(ir_c), .in_dot(d_c),
      .in_last(l_c), .out_valid(ov_c), .out_ready(or_c), .out_sum(s_c),
      .out_beats(b_c), .out_ovf(ovf_c), .out_trunc(tr_c)
   );

   typedef struct {
      logic        v;
      logic [18:0] d;
      logic        l;
      logic        ordy;
      logic        ev;
      logic        er;
      logic [31:0] es;
      logic [8:0]  eb;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(logic v, logic [18:0] d, logic l, logic ordy,
                               logic ev, logic er, logic [31:0] es, logic [8:0] eb);
      vec_t r;
      r.v = v; r.d = d; r.l = l; r.ordy = ordy;
      r.ev = ev; r.er = er; r.es = es; r.eb = eb;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_a_valid", {31'd0, ov_a}, 32'd0);
      chk("rst_a_sum", s_a, 32'd0);
      chk("rst_a_beats", {23'd0, b_a}, 32'd0);
      chk("rst_a_flags", {30'd0, ovf_a, tr_a}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cyc();
      chk("rst_a_ready", {31'd0, ir_a}, 32'd1);
      chk("rst_c_ready", {31'd0, ir_c}, 32'd1);

      // single beat, sum of four, backpressure, restart with held beat
      vecs.push_back(mk(1, 19'd520200, 1, 1, 1, 0, 32'd520200, 9'd1));
      vecs.push_back(mk(0, 19'd0,      0, 1, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(1, 19'd100,    0, 1, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(1, 19'd200,    0, 1, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(1, 19'd300,    0, 1, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(0, 19'd12345,  1, 1, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(1, 19'd400,    1, 1, 1, 0, 32'd1000, 9'd4));
      vecs.push_back(mk(0, 19'd0,      0, 1, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(1, 19'd7,      0, 0, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(1, 19'd8,      1, 0, 1, 0, 32'd15, 9'd2));
      for (int k = 0; k < 5; k++)
         vecs.push_back(mk(1, 19'd9, 0, 0, 1, 0, 32'd15, 9'd2));
      vecs.push_back(mk(1, 19'd9,      0, 1, 0, 1, 32'd0, 9'd0));
      vecs.push_back(mk(1, 19'd9,      1, 1, 1, 0, 32'd9, 9'd1));
      vecs.push_back(mk(0, 19'd0,      0, 1, 0, 1, 32'd0, 9'd0));

      for (int i = 0; i < vecs.size(); i++) begin
         v_a = vecs[i].v; d_a = vecs[i].d; l_a = vecs[i].l; or_a = vecs[i].ordy;
         cyc();
         chk($sformatf("vec%0d_valid", i), {31'd0, ov_a}, {31'd0, vecs[i].ev});
         chk($sformatf("vec%0d_ready", i), {31'd0, ir_a}, {31'd0, vecs[i].er});
         if (vecs[i].ev) begin
            chk($sformatf("vec%0d_sum", i), s_a, vecs[i].es);
            chk($sformatf("vec%0d_beats", i), {23'd0, b_a}, {23'd0, vecs[i].eb});
            chk($sformatf("vec%0d_flags", i), {30'd0, ovf_a, tr_a}, 32'd0);
         end
      end

      // saturation with ACC_W=20
      or_b = 1'b1;
      for (int i = 0; i < 3; i++) begin
         v_b = 1'b1; d_b = 19'd520200; l_b = (i == 2);
         cyc();
      end
      v_b = 1'b0; l_b = 1'b0;
      chk("sat_valid", {31'd0, ov_b}, 32'd1);
      chk("sat_sum", {12'd0, s_b}, 32'd1048575);
      chk("sat_ovf", {31'd0, ovf_b}, 32'd1);
      chk("sat_beats", {23'd0, b_b}, 32'd3);
      chk("sat_trunc", {31'd0, tr_b}, 32'd0);
      cyc();
      chk("sat_idle", {31'd0, ov_b}, 32'd0);

      // forced close with MAX_BEATS=4: six beats of 1, last on the sixth
      or_c = 1'b1; v_c = 1'b1; d_c = 19'd1; l_c = 1'b0;
      for (int i = 0; i < 4; i++) cyc();
      chk("max_valid1", {31'd0, ov_c}, 32'd1);
      chk("max_sum1", s_c, 32'd4);
      chk("max_beats1", {29'd0, b_c}, 32'd4);
      chk("max_trunc1", {31'd0, tr_c}, 32'd1);
      chk("max_ready_done", {31'd0, ir_c}, 32'd0);
      cyc();
      chk("max_hs_valid", {31'd0, ov_c}, 32'd0);
      chk("max_hs_ready", {31'd0, ir_c}, 32'd1);
      cyc();
      l_c = 1'b1;
      cyc();
      v_c = 1'b0; l_c = 1'b0;
      chk("max_valid2", {31'd0, ov_c}, 32'd1);
      chk("max_sum2", s_c, 32'd2);
      chk("max_beats2", {29'd0, b_c}, 32'd2);
      chk("max_trunc2", {31'd0, tr_c}, 32'd0);
      cyc();

      // asynchronous reset mid-frame
      or_a = 1'b1; v_a = 1'b1; d_a = 19'd50; l_a = 1'b0;
      cyc();
      cyc();
      v_a = 1'b0;
      chk("pre_rst_beats", {23'd0, b_a}, 32'd2);
      #2 rst = 1'b1;
      #1;
      chk("arst_valid", {31'd0, ov_a}, 32'd0);
      chk("arst_sum", s_a, 32'd0);
      chk("arst_beats", {23'd0, b_a}, 32'd0);
      chk("arst_flags", {30'd0, ovf_a, tr_a}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      v_a = 1'b1; d_a = 19'd5; l_a = 1'b1;
      cyc();
      v_a = 1'b0; l_a = 1'b0;
      chk("post_rst_valid", {31'd0, ov_a}, 32'd1);
      chk("post_rst_sum", s_a, 32'd5);
      chk("post_rst_beats", {23'd0, b_a}, 32'd1);
      cyc();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/dot_product_accum.md
Name: dot_product_accum

Overview:
- Streaming accumulator directly downstream of the 8-element byte dot-product stage.
- Consumes one 19-bit partial dot product per accepted beat and sums a frame of beats (a long vector split into 8-element chunks) into a wide result.
- Emits the frame result with beat count and status flags over a valid/ready handshake.
- Feeds result consumers such as the writeback or compare stage.

Parameters:
- IN_W, 19, width of incoming partial dot product (unsigned).
- ACC_W, 32, accumulator and result width; must be >= IN_W.
- MAX_BEATS, 256, maximum beats per frame before a forced close.
- CNT_W, $clog2(MAX_BEATS+1), beat counter width (derived).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  partial product valid.
- in_ready  out  1  accumulator can accept a beat.
- in_dot  in  IN_W  partial dot product, unsigned.
- in_last  in  1  final beat of frame.
- out_valid  out  1  frame result valid.
- out_ready  in  1  downstream accepts result.
- out_sum  out  ACC_W  frame sum.
- out_beats  out  CNT_W  number of beats accumulated in frame.
- out_ovf  out  1  sum saturated during frame.
- out_trunc  out  1  frame force-closed at MAX_BEATS without in_last.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state=IDLE, acc=0, count=0, all flags=0, out_valid=0, out_sum=0, out_beats=0, out_ovf=0, out_trunc=0. in_ready=1 from the first cycle after reset deasserts.
- State machine (enum in package):
  - IDLE: no beat in current frame.
  - ACCUM: at least one beat accepted.
  - DONE: result held.
- in_ready = (state != DONE). No same-cycle bypass from DONE to new input.
- Accept = in_valid && in_ready. in_dot and in_last are ignored when in_valid=0.
- On accept:
  - base = 0 in IDLE, acc in ACCUM.
  - sum = base + zero-extended in_dot, computed at ACC_W+1 bits.
  - If the carry bit is set: acc = all-ones and ovf becomes sticky 1; otherwise acc = sum[ACC_W-1:0].
  - count = (IDLE ? 1 : count+1).
- Close condition: accept with in_last=1, or the accept that makes count == MAX_BEATS.
  - trunc = 1 only when count reaches MAX_BEATS and in_last=0.
  - in_last on exactly the MAX_BEATS-th beat gives trunc=0.
  - On close, next state is DONE; otherwise next state is ACCUM.
- Latency: last beat accepted on edge N gives out_valid=1 from edge N, visible in cycle N+1. Output regs load on that edge.
- DONE:
  - out_valid=1; out_sum, out_beats, out_ovf, out_trunc held stable until handshake.
  - out_valid=1 && out_ready=1 moves to IDLE; out_valid falls, flags and count clear, acc is not used again.
- Peak throughput: one frame per (beats + 1) cycles when out_ready=1.
- Asynchronous reset during ACCUM or DONE discards the partial or unconsumed frame; no output is produced for it.
- Saturation stays sticky: later beats still increment count, and acc stays all-ones.

Decomposition:
- Package dot_pkg holds:
  - ELEM_W=8, NUM_ELEMENTS=8, DOT_W=19.
  - accum_state_t enum {IDLE, ACCUM, DONE}.
  - Default ACC_W constant.
- One combinational sub-module, dot_sat_add #(IN_W, ACC_W): inputs a, b; outputs sum, sat.
- FSM, counter and output registers stay in dot_product_accum.

Test Plan:
- Single beat in_dot=520200 with in_last=1, out_ready=1 → out_valid next cycle with out_sum=520200, out_beats=1, out_ovf=0, out_trunc=0; IDLE one cycle after.
- Beats 100, 200, 300, 400 on consecutive cycles, last on 400 → out_sum=1000, out_beats=4; in_ready=0 only during the DONE cycle.
- Backpressure: frame of 7 and 8 with last, out_ready=0 for 5 cycles, in_valid held high with in_dot=9 →
  - out_valid stays 1, out_sum=15 stable, in_ready=0, no beat 9 accepted.
  - After out_ready=1, the next frame starts with 9.
- ACC_W=20: three beats of 520200, last on third → out_sum=1048575, out_ovf=1, out_beats=3.
- MAX_BEATS=4: six beats of 1, last on sixth →
  - First result: out_sum=4, out_beats=4, out_trunc=1.
  - Second result: out_sum=2, out_beats=2, out_trunc=0.
- Reset asserted asynchronously after 2 beats of 50 → all outputs 0 immediately. Then a single beat 5 with last → out_sum=5, out_beats=1.
